load_store_unit: RTL

Parametrised load/store execution unit for the out-of-order core. It accepts one memory instruction at a time from the issue stage and computes the effective address. It drives a byte-lane-aligned request to the data cache, then returns a sign- or zero-extended load result or store completion to the common data bus stage. Compared with the first-generation unit, it adds:
- an explicit issue handshake
- byte enables with sub-word alignment
- a parametrised tag
- flush support
- a cache-response timeout

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 23 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// pkg_defines: opcode, state and access-size types plus opcode decoding for the load/store unit
package pkg_defines;
  typedef enum logic [3:0] {OP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW} instr_name_e;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} lsu_state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} lsu_size_e;
  typedef struct packed {
    logic      mem;
    logic      store;
    logic      sgn;
    lsu_size_e size;
  } lsu_op_t;
  function automatic lsu_op_t decode_op(input instr_name_e op);
    lsu_op_t d;
    d.mem   = op inside {LB, LBU, LH, LHU, LW, SB, SH, SW};
    d.store = op inside {SB, SH, SW};
    d.sgn   = op inside {LB, LH};
    d.size  = op inside {LB, LBU, SB} ? BYTE : op inside {LH, LHU, SH} ? HALF : WORD;
    return d;
  endfunction
  function automatic logic is_aligned(input lsu_size_e s, input logic [1:0] off);
    return s == BYTE || (s == HALF && !off[0]) || off == 2'b00;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store lane shift and load extraction/extension
module lsu_lane_align
  import pkg_defines::*;
(
  input  lsu_size_e   i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);
  logic [31:0] shifted;
  // lanes move by whole bytes; loads shift the word down then extend from the access width
  always_comb begin
    o_byte_en   = (i_size == BYTE ? 4'b0001 : i_size == HALF ? 4'b0011 : 4'b1111) << i_offset;
    o_wdata     = i_store_data << {i_offset, 3'b000};
    shifted     = i_rdata >> {i_offset, 3'b000};
    o_load_data = i_size == BYTE ? {{24{i_signed & shifted[7]}}, shifted[7:0]} :
                  i_size == HALF ? {{16{i_signed & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store execution with flush and timeout; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
  import pkg_defines::*;
#(
  parameter int TAG_WIDTH = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_accept,
  input  instr_name_e          i_instr_name,
  input  logic [31:0]          i_base,
  input  logic [31:0]          i_store_data,
  input  logic [31:0]          i_immediate,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_flush,
  output logic [31:0]          o_cache_address,
  output logic                 o_cache_read,
  output logic                 o_cache_write,
  output logic [31:0]          o_cache_wdata,
  output logic [3:0]           o_cache_byte_en,
  output logic [TAG_WIDTH-1:0] o_cache_tag,
  input  logic [31:0]          i_cache_rdata,
  input  logic                 i_cache_hit,
  input  logic                 i_cache_ready,
  output logic                 o_valid,
  output logic [31:0]          o_result,
  output logic [31:0]          o_store_address,
  output logic [TAG_WIDTH-1:0] o_result_tag,
  output logic                 o_fault
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  lsu_state_e           state_q, state_d;
  lsu_op_t              op_q, op_d, dec;
  logic [31:0]          ea_q, ea_d, data_q, data_d, ea_raw, ea_fix;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, result_tag_q, result_tag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, valid_d, fault_q, fault_d;
  logic [31:0]          result_q, result_d, store_addr_q, store_addr_d;
  logic [3:0]           byte_en;
  logic [31:0]          wdata, load_data;
  logic                 take, waiting, response, timed_out, misalign;
  assign dec       = decode_op(i_instr_name);
  assign ea_raw    = i_base + i_immediate;
`ifdef LSU_MISALIGN_TRAP_EN
  assign ea_fix    = ea_raw;
  assign misalign  = !is_aligned(dec.size, ea_raw[1:0]);
`else
  assign ea_fix    = dec.size == HALF ? {ea_raw[31:1], 1'b0} : dec.size == WORD ? {ea_raw[31:2], 2'b00} : ea_raw;
  assign misalign  = 1'b0;
`endif
  assign o_accept  = state_q == IDLE && !i_flush;
  assign take      = i_valid && o_accept && dec.mem;
  assign waiting   = state_q != IDLE;
  assign response  = state_q == LOAD_WAIT ? i_cache_hit : state_q == STORE_WAIT && i_cache_ready;
  assign timed_out = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  lsu_lane_align u_align (
    .i_size       (op_q.size),
    .i_signed     (op_q.sgn),
    .i_offset     (ea_q[1:0]),
    .i_store_data (data_q),
    .i_rdata      (i_cache_rdata),
    .o_byte_en    (byte_en),
    .o_wdata      (wdata),
    .o_load_data  (load_data)
  );
  assign o_cache_read    = state_q == LOAD_WAIT;
  assign o_cache_write   = state_q == STORE_WAIT;
  assign o_cache_address = {ea_q[31:2], 2'b00};
  assign o_cache_byte_en = waiting ? byte_en : 4'b0000;
  assign o_cache_wdata   = o_cache_write ? wdata : 32'd0;
  assign o_cache_tag     = tag_q;
  assign o_valid         = valid_q;
  assign o_fault         = fault_q;
  assign o_result        = result_q;
  assign o_store_address = store_addr_q;
  assign o_result_tag    = result_tag_q;
  // accept, wait for the matching response, and retire on response, timeout, trap or flush
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ea_d         = ea_q;
    data_d       = data_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    valid_d      = 1'b0;
    fault_d      = 1'b0;
    result_d     = result_q;
    store_addr_d = store_addr_q;
    result_tag_d = result_tag_q;
    if (take) begin
      op_d   = dec;
      ea_d   = ea_fix;
      data_d = i_store_data;
      tag_d  = i_tag;
      cnt_d  = '0;
      if (misalign) begin
        valid_d      = 1'b1;
        fault_d      = 1'b1;
        result_d     = ea_raw;
        store_addr_d = 32'd0;
        result_tag_d = i_tag;
      end else begin
        state_d = dec.store ? STORE_WAIT : LOAD_WAIT;
      end
    end else if (waiting) begin
      if (i_flush) begin
        state_d = IDLE;
      end else if (response) begin
        state_d      = IDLE;
        valid_d      = 1'b1;
        result_d     = op_q.store ? data_q : load_data;
        store_addr_d = op_q.store ? ea_q : 32'd0;
        result_tag_d = tag_q;
      end else if (timed_out) begin
        state_d      = IDLE;
        valid_d      = 1'b1;
        fault_d      = 1'b1;
        result_d     = 32'd0;
        store_addr_d = 32'd0;
        result_tag_d = tag_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  // state and output registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      ea_q         <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      result_q     <= '0;
      store_addr_q <= '0;
      result_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ea_q         <= ea_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      result_q     <= result_d;
      store_addr_q <= store_addr_d;
      result_tag_q <= result_tag_d;
    end
  end
endmodule
